riscv_retire_checker: RTL and testbench
=======================================

Name: riscv_retire_checker

Overview:
- Synthesizable self-check monitor for the RISCV_TOP core. Compares OUTPUT_PORT against a loadable table of (instruction count, expected value) pairs as NUM_INST advances.
- Supports a configurable number of checkpoints, a stop-on-fail or continue mode, a cycle timeout, and pass/fail counters.
- Sits beside the core on the NUM_INST, OUTPUT_PORT and HALT signals. Results are readable on FPGA or in the bench without $display.

Parameters:
- NUM_TEST, 32, table depth (max checkpoints)
- DWIDTH, 32, width of NUM_INST, OUTPUT_PORT and table fields
- IDX_W, 5, clog2(NUM_TEST); index width
- CNT_W, 32, cycle counter width
- TIMEOUT, 1000000, cycle limit in RUN before forced fail

Ports:
- CLK  in  1  clock
- RSTn  in  1  synchronous active-low reset
- CFG_WE  in  1  table write strobe
- CFG_IDX  in  IDX_W  table entry to write
- CFG_NUM_INST  in  DWIDTH  checkpoint instruction count
- CFG_ANS  in  DWIDTH  expected OUTPUT_PORT value
- CFG_NTEST  in  IDX_W+1  active entry count, sampled on START
- START  in  1  begin a run (pulse)
- STOP_ON_FAIL  in  1  mode, sampled on START
- NUM_INST  in  DWIDTH  core retired-instruction count
- OUTPUT_PORT  in  DWIDTH  core output value
- HALT  in  1  core halt
- BUSY  out  1  in RUN
- DONE  out  1  run finished (PASS or FAIL state)
- PASS  out  1  run finished with all checkpoints matched
- FAIL  out  1  run finished with a failure
- MISS  out  1  first failure was a skipped checkpoint
- TMO  out  1  run ended by timeout
- FAIL_IDX  out  IDX_W  index of first failing entry
- FAIL_GOT  out  DWIDTH  OUTPUT_PORT value at first failure
- PASS_CNT  out  IDX_W+1  checkpoints passed
- FAIL_CNT  out  IDX_W+1  checkpoints failed
- CYCLE_CNT  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset (RSTn=0 at posedge):
  - State goes to IDLE. All outputs are 0, as are ptr, the sampled ntest and the sampled mode.
  - Table contents are not reset.
  - Reset mid-run aborts immediately. No result is reported.
- Table writes:
  - CFG_WE writes entry[CFG_IDX] = {CFG_NUM_INST, CFG_ANS} in IDLE, PASS and FAIL states.
  - CFG_WE is ignored in RUN.
  - CFG_IDX >= NUM_TEST is ignored.
- Table order: entries 0..ntest-1 must have strictly increasing NUM_INST. A violation shows up as a MISS.
- State IDLE, PASS or FAIL, on START:
  - Go to RUN.
  - Clear ptr, PASS_CNT, FAIL_CNT, CYCLE_CNT and all flags.
  - Latch CFG_NTEST (saturated to NUM_TEST) and STOP_ON_FAIL.
- State RUN, each cycle:
  - CYCLE_CNT increments.
  - When ptr < ntest, let tgt = entry[ptr].num_inst:
    - NUM_INST == tgt and OUTPUT_PORT == ans: PASS_CNT+1, ptr+1.
    - NUM_INST == tgt and OUTPUT_PORT != ans: failure.
    - NUM_INST > tgt: failure with MISS=1.
    - NUM_INST < tgt: nothing.
  - On a failure:
    - The first failure captures FAIL_IDX=ptr and FAIL_GOT=OUTPUT_PORT.
    - FAIL_CNT+1.
    - If stop-on-fail is set, go to FAIL next cycle. Otherwise ptr+1 and continue.
  - At most one entry is consumed per cycle.
- HALT in RUN:
  - The same-cycle checkpoint compare is applied first.
  - Then go to PASS if FAIL_CNT==0 and ptr==ntest (after the update), else FAIL.
  - Unreached entries are not counted in FAIL_CNT. They cause FAIL only through ptr != ntest.
- Timeout: CYCLE_CNT == TIMEOUT-1 in RUN without HALT goes to FAIL with TMO=1. HALT in the same cycle takes priority.
- ntest==0: the run passes on the first HALT.
- PASS and FAIL states hold all results stable until START or reset. START re-arms.
- Outputs are registered: DONE, PASS and FAIL assert 1 cycle after the deciding edge.
- Counters saturate at max and never wrap.

Decomposition:
- Package riscv_chk_pkg holds:
  - State enum (IDLE, RUN, PASS_ST, FAIL_ST) and the entry struct {num_inst, ans}.
  - Default NUM_TEST/TIMEOUT constants.
- One natural sub-module, riscv_chk_table: register-array table with the write port and an asynchronous read at ptr.
- FSM and counters stay in the top.

Test Plan:
- Load 3 entries {(1,0),(3,5),(10,0xF)}, ntest=3, START; drive NUM_INST 0..12 with matching OUTPUT_PORT, HALT at 12 -> PASS=1, PASS_CNT=3, FAIL_CNT=0, CYCLE_CNT=13.
- Same table, OUTPUT_PORT=4 at NUM_INST=3, STOP_ON_FAIL=1 -> FAIL=1, FAIL_IDX=1, FAIL_GOT=4, MISS=0, PASS_CNT=1. HALT is ignored afterwards.
- Same mismatch with STOP_ON_FAIL=0, HALT at 12 -> FAIL=1, PASS_CNT=2, FAIL_CNT=1, FAIL_IDX=1.
- NUM_INST jumps from 2 to 4 (skips entry 1) -> FAIL_CNT+1, MISS=1, FAIL_IDX=1.
- TIMEOUT=20, no HALT -> FAIL=1 and TMO=1 at CYCLE_CNT=19. HALT on cycle 19 instead -> PASS if all matched.
- RSTn=0 mid-run, then START with ntest=0 and HALT on the first cycle -> outputs cleared on reset, then PASS=1, PASS_CNT=0. CFG_WE during RUN leaves the table unchanged (read back by a new run).

Source files
------------

// File: rtl/riscv_chk_pkg.sv
// Shared types and defaults for the RISCV_TOP retire checker.
package riscv_chk_pkg;

    localparam int DEF_NUM_TEST = 32;
    localparam int DEF_TIMEOUT  = 1000000;
    localparam int DEF_DWIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PASS_ST = 2'd2,
        FAIL_ST = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic [DEF_DWIDTH-1:0] num_inst;
        logic [DEF_DWIDTH-1:0] ans;
    } chk_entry_t;

endpackage

// File: rtl/riscv_chk_table.sv
// Checkpoint table: register array with one write port and an async read.
module riscv_chk_table
    import riscv_chk_pkg::*;
#(
    parameter int NUM_TEST = DEF_NUM_TEST,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int IDX_W    = 5
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DWIDTH-1:0] wr_num_inst,
    input  logic [DWIDTH-1:0] wr_ans,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DWIDTH-1:0] rd_num_inst,
    output logic [DWIDTH-1:0] rd_ans
);

    logic [DWIDTH-1:0] num_q [NUM_TEST];
    logic [DWIDTH-1:0] ans_q [NUM_TEST];

    logic wr_ok;
    logic rd_ok;

    always_comb begin
        wr_ok = we && (int'(wr_idx) < NUM_TEST);
        rd_ok = int'(rd_idx) < NUM_TEST;
    end

    // Contents deliberately survive reset so a table can be reused across runs.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            num_q[wr_idx] <= wr_num_inst;
            ans_q[wr_idx] <= wr_ans;
        end
    end

    assign rd_num_inst = rd_ok ? num_q[rd_idx] : '0;
    assign rd_ans      = rd_ok ? ans_q[rd_idx] : '0;

endmodule

// File: rtl/riscv_retire_checker.sv
// Self-check monitor: compares OUTPUT_PORT against a table of
// (retired-instruction count, expected value) checkpoints.
module riscv_retire_checker
    import riscv_chk_pkg::*;
#(
    parameter int NUM_TEST = DEF_NUM_TEST,
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CFG_WE,
    input  logic [IDX_W-1:0]  CFG_IDX,
    input  logic [DWIDTH-1:0] CFG_NUM_INST,
    input  logic [DWIDTH-1:0] CFG_ANS,
    input  logic [IDX_W:0]    CFG_NTEST,
    input  logic              START,
    input  logic              STOP_ON_FAIL,
    input  logic [DWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              FAIL,
    output logic              MISS,
    output logic              TMO,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_GOT,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [IDX_W:0]    FAIL_CNT,
    output logic [CNT_W-1:0]  CYCLE_CNT
);

    localparam logic [IDX_W:0]   NTEST_MAX = (IDX_W+1)'(NUM_TEST);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    chk_state_e        state_q, state_d;
    logic [IDX_W:0]    ptr_q, ptr_d;
    logic [IDX_W:0]    ntest_q, ntest_d;
    logic              sof_q, sof_d;
    logic [IDX_W:0]    pass_cnt_q, pass_cnt_d;
    logic [IDX_W:0]    fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              miss_q, miss_d;
    logic              tmo_q, tmo_d;
    logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
    logic [DWIDTH-1:0] fail_got_q, fail_got_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;

    logic              tbl_we;
    logic [DWIDTH-1:0] tgt;
    logic [DWIDTH-1:0] ans;
    logic              fail_now;
    logic              miss_now;
    logic [CNT_W-1:0]  cyc_inc;

    riscv_chk_table #(
        .NUM_TEST (NUM_TEST),
        .DWIDTH   (DWIDTH),
        .IDX_W    (IDX_W)
    ) u_table (
        .CLK         (CLK),
        .we          (tbl_we),
        .wr_idx      (CFG_IDX),
        .wr_num_inst (CFG_NUM_INST),
        .wr_ans      (CFG_ANS),
        .rd_idx      (ptr_q[IDX_W-1:0]),
        .rd_num_inst (tgt),
        .rd_ans      (ans)
    );

    always_comb begin
        tbl_we     = CFG_WE && (state_q != RUN);
        cyc_inc    = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

        state_d    = state_q;
        ptr_d      = ptr_q;
        ntest_d    = ntest_q;
        sof_d      = sof_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        cyc_d      = cyc_q;
        miss_d     = miss_q;
        tmo_d      = tmo_q;
        fail_idx_d = fail_idx_q;
        fail_got_d = fail_got_q;
        fail_now   = 1'b0;
        miss_now   = 1'b0;

        case (state_q)
            RUN: begin
                if (ptr_q < ntest_q) begin
                    if (NUM_INST == tgt) begin
                        if (OUTPUT_PORT == ans) begin
                            pass_cnt_d = (&pass_cnt_q) ? pass_cnt_q : pass_cnt_q + 1'b1;
                            ptr_d      = ptr_q + 1'b1;
                        end else begin
                            fail_now = 1'b1;
                        end
                    end else if (NUM_INST > tgt) begin
                        fail_now = 1'b1;
                        miss_now = 1'b1;
                    end
                end

                if (fail_now) begin
                    if (fail_cnt_q == '0) begin
                        fail_idx_d = ptr_q[IDX_W-1:0];
                        fail_got_d = OUTPUT_PORT;
                        miss_d     = miss_now;
                    end
                    fail_cnt_d = (&fail_cnt_q) ? fail_cnt_q : fail_cnt_q + 1'b1;
                    if (!sof_q) ptr_d = ptr_q + 1'b1;
                end

                // HALT wins over timeout; the timeout cycle itself is not counted.
                if (HALT) begin
                    cyc_d   = cyc_inc;
                    state_d = (fail_cnt_d == '0 && ptr_d == ntest_q) ? PASS_ST : FAIL_ST;
                end else if (fail_now && sof_q) begin
                    cyc_d   = cyc_inc;
                    state_d = FAIL_ST;
                end else if (cyc_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = FAIL_ST;
                end else begin
                    cyc_d   = cyc_inc;
                end
            end
            default: begin
                if (START) begin
                    state_d    = RUN;
                    ptr_d      = '0;
                    ntest_d    = (CFG_NTEST > NTEST_MAX) ? NTEST_MAX : CFG_NTEST;
                    sof_d      = STOP_ON_FAIL;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    cyc_d      = '0;
                    miss_d     = 1'b0;
                    tmo_d      = 1'b0;
                    fail_idx_d = '0;
                    fail_got_d = '0;
                end
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == PASS_ST) || (state_d == FAIL_ST);
        pass_d = (state_d == PASS_ST);
        fail_d = (state_d == FAIL_ST);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ntest_q    <= '0;
            sof_q      <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            cyc_q      <= '0;
            miss_q     <= 1'b0;
            tmo_q      <= 1'b0;
            fail_idx_q <= '0;
            fail_got_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ntest_q    <= ntest_d;
            sof_q      <= sof_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            cyc_q      <= cyc_d;
            miss_q     <= miss_d;
            tmo_q      <= tmo_d;
            fail_idx_q <= fail_idx_d;
            fail_got_q <= fail_got_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL      = fail_q;
    assign MISS      = miss_q;
    assign TMO       = tmo_q;
    assign FAIL_IDX  = fail_idx_q;
    assign FAIL_GOT  = fail_got_q;
    assign PASS_CNT  = pass_cnt_q;
    assign FAIL_CNT  = fail_cnt_q;
    assign CYCLE_CNT = cyc_q;

endmodule

// File: tb/tb_riscv_retire_checker.sv
// Directed bench for riscv_retire_checker; table {(1,0),(3,5),(10,0xF)}, TIMEOUT=20.
module tb_riscv_retire_checker;

    localparam int NUM_TEST = 32;
    localparam int DWIDTH   = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 32;
    localparam int TIMEOUT  = 20;

    logic              CLK = 1'b0;
    logic              RSTn;
    logic              CFG_WE;
    logic [IDX_W-1:0]  CFG_IDX;
    logic [DWIDTH-1:0] CFG_NUM_INST;
    logic [DWIDTH-1:0] CFG_ANS;
    logic [IDX_W:0]    CFG_NTEST;
    logic              START;
    logic              STOP_ON_FAIL;
    logic [DWIDTH-1:0] NUM_INST;
    logic [DWIDTH-1:0] OUTPUT_PORT;
    logic              HALT;
    logic              BUSY, DONE, PASS, FAIL, MISS, TMO;
    logic [IDX_W-1:0]  FAIL_IDX;
    logic [DWIDTH-1:0] FAIL_GOT;
    logic [IDX_W:0]    PASS_CNT, FAIL_CNT;
    logic [CNT_W-1:0]  CYCLE_CNT;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_retire_checker #(
        .NUM_TEST (NUM_TEST),
        .DWIDTH   (DWIDTH),
        .IDX_W    (IDX_W),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .CFG_WE       (CFG_WE),
        .CFG_IDX      (CFG_IDX),
        .CFG_NUM_INST (CFG_NUM_INST),
        .CFG_ANS      (CFG_ANS),
        .CFG_NTEST    (CFG_NTEST),
        .START        (START),
        .STOP_ON_FAIL (STOP_ON_FAIL),
        .NUM_INST     (NUM_INST),
        .OUTPUT_PORT  (OUTPUT_PORT),
        .HALT         (HALT),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .PASS         (PASS),
        .FAIL         (FAIL),
        .MISS         (MISS),
        .TMO          (TMO),
        .FAIL_IDX     (FAIL_IDX),
        .FAIL_GOT     (FAIL_GOT),
        .PASS_CNT     (PASS_CNT),
        .FAIL_CNT     (FAIL_CNT),
        .CYCLE_CNT    (CYCLE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int idx, input int ni, input int a);
        CFG_WE       = 1'b1;
        CFG_IDX      = IDX_W'(idx);
        CFG_NUM_INST = DWIDTH'(ni);
        CFG_ANS      = DWIDTH'(a);
        tick();
        CFG_WE       = 1'b0;
    endtask

    task automatic go(input int ntest, input logic sof);
        CFG_NTEST    = (IDX_W+1)'(ntest);
        STOP_ON_FAIL = sof;
        START        = 1'b1;
        tick();
        START        = 1'b0;
    endtask

    task automatic step(input int ni, input int op, input logic halt);
        NUM_INST    = DWIDTH'(ni);
        OUTPUT_PORT = DWIDTH'(op);
        HALT        = halt;
        tick();
        HALT        = 1'b0;
    endtask

    // Expected core output at each checkpoint of the default table.
    function automatic int ref_out(input int ni);
        case (ni)
            1:       return 0;
            3:       return 5;
            10:      return 15;
            default: return 32'hAA;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTn = 1'b0; CFG_WE = 1'b0; CFG_IDX = '0; CFG_NUM_INST = '0; CFG_ANS = '0;
        CFG_NTEST = '0; START = 1'b0; STOP_ON_FAIL = 1'b0;
        NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
        tick(); tick();
        RSTn = 1'b1;
        chk("rst_flags", {58'd0, BUSY, DONE, PASS, FAIL, MISS, TMO}, 64'd0);
        chk("rst_cnts", {PASS_CNT, FAIL_CNT, CYCLE_CNT}, 64'd0);
        chk("rst_fail_info", {FAIL_IDX, FAIL_GOT}, 64'd0);

        wr(0, 1, 0);
        wr(1, 3, 5);
        wr(2, 10, 15);

        // All checkpoints match.
        go(3, 1'b0);
        chk("t1_busy", BUSY, 1);
        for (int i = 0; i <= 12; i++) step(i, ref_out(i), i == 12);
        chk("t1_pass", {DONE, PASS, FAIL, BUSY}, 4'b1100);
        chk("t1_pass_cnt", PASS_CNT, 3);
        chk("t1_fail_cnt", FAIL_CNT, 0);
        chk("t1_cycles", CYCLE_CNT, 13);

        // Mismatch at entry 1, stop on fail; later HALT must not change anything.
        go(3, 1'b1);
        for (int i = 0; i <= 3; i++) step(i, (i == 3) ? 4 : ref_out(i), 1'b0);
        chk("t2_fail", {DONE, PASS, FAIL}, 3'b101);
        chk("t2_fail_idx", FAIL_IDX, 1);
        chk("t2_fail_got", FAIL_GOT, 4);
        chk("t2_miss", MISS, 0);
        chk("t2_pass_cnt", PASS_CNT, 1);
        chk("t2_fail_cnt", FAIL_CNT, 1);
        step(4, 0, 1'b1);
        step(5, 0, 1'b1);
        chk("t2_hold", {DONE, PASS, FAIL}, 3'b101);
        chk("t2_hold_cycles", CYCLE_CNT, 4);

        // Same mismatch, continue mode.
        go(3, 1'b0);
        for (int i = 0; i <= 12; i++) step(i, (i == 3) ? 4 : ref_out(i), i == 12);
        chk("t3_fail", {PASS, FAIL}, 2'b01);
        chk("t3_pass_cnt", PASS_CNT, 2);
        chk("t3_fail_cnt", FAIL_CNT, 1);
        chk("t3_fail_idx", FAIL_IDX, 1);
        chk("t3_miss", MISS, 0);

        // Skip entry 1 (NUM_INST 2 -> 4).
        go(3, 1'b0);
        for (int i = 0; i <= 12; i++) begin
            if (i != 3) step(i, ref_out(i), i == 12);
        end
        chk("t4_fail", {PASS, FAIL}, 2'b01);
        chk("t4_miss", MISS, 1);
        chk("t4_fail_idx", FAIL_IDX, 1);
        chk("t4_fail_got", FAIL_GOT, 32'hAA);
        chk("t4_fail_cnt", FAIL_CNT, 1);
        chk("t4_pass_cnt", PASS_CNT, 2);
        chk("t4_cycles", CYCLE_CNT, 12);

        // Timeout without HALT.
        begin
            int n;
            n = 0;
            go(3, 1'b0);
            while (!DONE && n < 40) begin
                step(0, 0, 1'b0);
                n++;
            end
            chk("t5_tmo_steps", n, 20);
            chk("t5_tmo", {FAIL, TMO, PASS}, 3'b110);
            chk("t5_cycles", CYCLE_CNT, 19);
            chk("t5_fail_cnt", FAIL_CNT, 0);
        end

        // HALT on the timeout cycle wins.
        go(3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step((i <= 12) ? i : 12, ref_out((i <= 12) ? i : 12), i == 19);
            if (i == 18) chk("t5b_not_done", DONE, 0);
        end
        chk("t5b_pass", {PASS, FAIL, TMO}, 3'b100);
        chk("t5b_cycles", CYCLE_CNT, 20);
        chk("t5b_pass_cnt", PASS_CNT, 3);

        // Reset mid-run.
        go(3, 1'b0);
        step(0, 0, 1'b0);
        step(1, 0, 1'b0);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        chk("t6_rst_flags", {58'd0, BUSY, DONE, PASS, FAIL, MISS, TMO}, 64'd0);
        chk("t6_rst_cnts", {PASS_CNT, FAIL_CNT, CYCLE_CNT}, 64'd0);

        // ntest=0 passes on first HALT.
        go(0, 1'b0);
        step(0, 0, 1'b1);
        chk("t6_nt0_pass", {DONE, PASS, FAIL}, 3'b110);
        chk("t6_nt0_pass_cnt", PASS_CNT, 0);
        chk("t6_nt0_cycles", CYCLE_CNT, 1);

        // Write during RUN is dropped; table survived the reset.
        go(3, 1'b0);
        for (int i = 0; i <= 12; i++) begin
            if (i == 0) begin
                CFG_WE = 1'b1; CFG_IDX = '0; CFG_NUM_INST = 2; CFG_ANS = 7;
            end
            step(i, ref_out(i), i == 12);
            CFG_WE = 1'b0;
        end
        chk("t7_we_run_pass", {PASS, FAIL}, 2'b10);
        chk("t7_we_run_cnt", PASS_CNT, 3);

        // Write in PASS state is accepted.
        wr(0, 2, 7);
        go(1, 1'b0);
        step(0, 0, 1'b0);
        step(1, 0, 1'b0);
        step(2, 7, 1'b1);
        chk("t8_we_pass", {PASS, FAIL}, 2'b10);
        chk("t8_we_pass_cnt", PASS_CNT, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
